// File: rtl/bank_req_seq.sv
// bank_req_seq: single-beat request front-end for one CIM/SRAM bank; times writes and reads
// from bank_ctrl phase outputs and returns sensed data through a one-entry response register.
module bank_req_seq #(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int WR_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_ack,
  output logic          w_en,
  output logic [AW-1:0] wl_addr,
  output logic [DW-1:0] din,
  input  logic          preb,
  input  logic          w_drv,
  input  logic          sa_en,
  input  logic [DW-1:0] sa_dout
);
  typedef enum logic [2:0] {IDLE, W_ARM, W_HOLD, W_END, R_SYNC, R_WAIT, RSP} state_t;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_req_ready, r_rsp_valid, r_wr_ack, r_w_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din, r_rdata;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign wr_ack    = r_wr_ack;
  assign w_en      = r_w_en;
  assign wl_addr   = r_addr;
  assign din       = r_din;
  assign rsp_rdata = r_rdata;
  // Outputs are registered alongside the state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_w_en      <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_rdata     <= '0;
    end else begin
      r_wr_ack <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr      <= req_addr;
          r_req_ready <= 1'b0;
          if (req_we) begin
            r_din   <= req_wdata;
            r_w_en  <= 1'b1;
            r_state <= W_ARM;
          end else r_state <= R_SYNC;
        end
        W_ARM: if (w_drv) begin
          r_cnt <= 8'd1;
          if (WR_CYC == 2) begin
            r_state  <= W_END;
            r_w_en   <= 1'b0;
            r_wr_ack <= 1'b1;
          end else r_state <= W_HOLD;
        end
        W_HOLD: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(WR_CYC - 2)) begin
            r_state  <= W_END;
            r_w_en   <= 1'b0;
            r_wr_ack <= 1'b1;
          end
        end
        W_END: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        // A full PRE must pass with the new address before a sense is trusted.
        R_SYNC: if (!preb) r_state <= R_WAIT;
        R_WAIT: if (sa_en) begin
          r_rdata     <= sa_dout;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bank_req_seq.sv
// tb_bank_req_seq: directed bench for bank_req_seq with a free-running bank_ctrl/array model;
// u0 uses WR_CYC=2, u1 uses WR_CYC=5.
module tb_bank_req_seq;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam logic [1:0] PRE = 2'd0, S1 = 2'd1, S2 = 2'd2, WR = 2'd3;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    ph;
    logic [7:0]    exp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b1, brst = 1'b1;
  logic rv0 = 1'b0, rv1 = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic rr0, rsv0, ack0, wen0, rr1, rsv1, ack1, wen1, wdrv0, wdrv1;
  logic [AW-1:0] wl0, wl1, ba0;
  logic [DW-1:0] din0, din1, rd0, rd1;
  logic [1:0] ph0, ph1;
  logic [DW-1:0] mem [64];
  int n_vec = 0, n_err = 0;
  vec_t tv [6];
  always #5 clk = ~clk;
  assign wdrv0 = ph0 == WR;
  assign wdrv1 = ph1 == WR;
  function automatic logic [1:0] bnext(input logic [1:0] p, input logic we);
    return p == PRE ? (we ? WR : S1) : p == S1 ? S2 : p == S2 ? PRE : (we ? WR : PRE);
  endfunction
  // Bank model: PRE/SENSE1/SENSE2 free-run; WRITE entered from PRE while w_en; address latched in PRE.
  always @(posedge clk)
    if (brst) begin
      ph0 <= S1;
      ph1 <= S1;
      ba0 <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= (i == 63) ? 32'h1234_5678 : 32'hDEAD_BEEF;
    end else begin
      ph0 <= bnext(ph0, wen0);
      ph1 <= bnext(ph1, wen1);
      if (ph0 == PRE) ba0 <= wl0;
      if (ph0 == WR) mem[wl0] <= din0;
    end
  bank_req_seq #(.AW(AW), .DW(DW), .WR_CYC(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsv0), .rsp_ready(rsp_ready),
    .rsp_rdata(rd0), .wr_ack(ack0), .w_en(wen0), .wl_addr(wl0), .din(din0),
    .preb(ph0 != PRE), .w_drv(wdrv0), .sa_en(ph0 == S2), .sa_dout(mem[ba0]));
  bank_req_seq #(.AW(AW), .DW(DW), .WR_CYC(5)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsv1), .rsp_ready(rsp_ready),
    .rsp_rdata(rd1), .wr_ack(ack1), .w_en(wen1), .wl_addr(wl1), .din(din1),
    .preb(ph1 != PRE), .w_drv(wdrv1), .sa_en(ph1 == S2), .sa_dout({DW{1'b0}}));
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic wait_ph(input int idx, input logic [1:0] p);
    int k = 0;
    while ((idx == 0 ? ph0 : ph1) != p && k < 8) begin
      tick();
      k++;
    end
    chk("bank_phase", idx == 0 ? ph0 : ph1, p);
  endtask
  initial begin
    int k, nw, na, aat, narm, nwen;
    logic [4:0] pat;
    tv[0] = '{1'b0, 6'h3F, 32'h1234_5678, S2,  8'd3};
    tv[1] = '{1'b1, 6'h15, 32'hA5A5_0F0F, PRE, 8'd2};
    tv[2] = '{1'b0, 6'h15, 32'hA5A5_0F0F, PRE, 8'd5};
    tv[3] = '{1'b1, 6'h00, 32'h0000_FFFF, S1,  8'd2};
    tv[4] = '{1'b0, 6'h00, 32'h0000_FFFF, S1,  8'd4};
    tv[5] = '{1'b0, 6'h3F, 32'h1234_5678, S2,  8'd3};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", rr0, 1);
    chk("rst_rsp_valid", rsv0, 0);
    chk("rst_wr_ack", ack0, 0);
    chk("rst_w_en", wen0, 0);
    chk("rst_wl_addr", wl0, 0);
    chk("rst_din", din0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_bank_s1", ph0, S1);
    rst_n = 1'b1;
    brst  = 1'b0;
    tick();
    chk("post_rst_ready", rr0, 1);
    chk("post_rst_w_en", wen0, 0);
    for (int i = 0; i < 6; i++) begin
      wait_ph(0, tv[i].ph);
      req_we = tv[i].we; req_addr = tv[i].addr; req_wdata = tv[i].data; rv0 = 1'b1;
      tick();
      rv0 = 1'b0;
      chk("acc_wl_addr", wl0, tv[i].addr);
      chk("acc_busy", rr0, 0);
      if (tv[i].we) begin
        chk("acc_din", din0, tv[i].data);
        nw = 0; na = 0; aat = 0; k = 0;
        while (!rr0 && k < 20) begin
          if (wdrv0) nw++;
          if (ack0) begin na++; aat = nw; end
          tick();
          k++;
        end
        chk("wr_done", rr0, 1);
        chk("wr_wdrv_cycles", nw, tv[i].exp);
        chk("wr_ack_count", na, 1);
        chk("wr_ack_pos", aat, 2);
      end else begin
        k = 0;
        while (!rsv0 && k < 20) begin tick(); k++; end
        chk("rd_latency", k, tv[i].exp);
        chk("rd_data", rd0, tv[i].data);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_rsp_done", rsv0, 0);
        chk("rd_ready_back", rr0, 1);
        chk("rd_data_hold", rd0, tv[i].data);
      end
    end
    // Response back-pressure with a waiting request
    wait_ph(0, S2);
    req_we = 1'b0; req_addr = 6'h15; rv0 = 1'b1;
    tick();
    req_addr = 6'h2A;
    k = 0;
    while (!rsv0 && k < 20) begin tick(); k++; end
    for (int j = 0; j < 4; j++) begin
      chk("bp_valid", rsv0, 1);
      chk("bp_data", rd0, 32'hA5A5_0F0F);
      chk("bp_busy", rr0, 0);
      chk("bp_wl_addr", wl0, 6'h15);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_valid", rsv0, 0);
    chk("bp_hs_ready", rr0, 1);
    chk("bp_no_accept", wl0, 6'h15);
    tick();
    rv0 = 1'b0;
    chk("bp_next_busy", rr0, 0);
    chk("bp_next_addr", wl0, 6'h2A);
    k = 0;
    while (!rsv0 && k < 20) begin tick(); k++; end
    chk("bp_next_data", rd0, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // WR_CYC=5 write accepted in SENSE1
    wait_ph(1, S1);
    req_we = 1'b1; req_addr = 6'h07; req_wdata = 32'hCAFE_0001; rv1 = 1'b1;
    tick();
    rv1 = 1'b0;
    chk("w5_wl_addr", wl1, 6'h07);
    chk("w5_din", din1, 32'hCAFE_0001);
    nw = 0; na = 0; aat = 0; narm = 0; pat = '0; k = 0;
    while (!rr1 && k < 20) begin
      if (wdrv1) begin nw++; pat = {pat[3:0], wen1}; end
      else if (wen1) narm++;
      if (ack1) begin na++; aat = nw; end
      tick();
      k++;
    end
    chk("w5_done", rr1, 1);
    chk("w5_wdrv_cycles", nw, 5);
    chk("w5_arm_wait", narm, 2);
    chk("w5_wen_pattern", pat, 5'b11110);
    chk("w5_ack_count", na, 1);
    chk("w5_ack_pos", aat, 5);
    // Asynchronous reset in W_HOLD
    req_addr = 6'h08; req_wdata = 32'h0BAD_F00D; rv1 = 1'b1;
    tick();
    rv1 = 1'b0;
    k = 0;
    while (!wdrv1 && k < 10) begin tick(); k++; end
    tick();
    chk("hold_active", wen1 && wdrv1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_w_en", wen1, 0);
    chk("arst_ready", rr1, 1);
    chk("arst_ack", ack1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    na = 0; nwen = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (ack1) na++;
      if (wen1) nwen++;
    end
    chk("arst_no_ack", na, 0);
    chk("arst_no_wen", nwen, 0);
    chk("arst_idle", rr1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
